// File: rtl/instruction_decode.sv
// instruction_decode: IF/ID pipeline register with an RV64I field/immediate/control decoder.
// The fetched word is decoded combinationally on the way in and every output is registered,
// so execute sees results one cycle after the fetch handshake.
//
// Optional build macro: ILLEGAL_CHECK_EN
//   defined   -> unknown opcodes raise illegal and freeze the stage until flush or reset
//   undefined -> illegal is tied 0 and unknown opcodes flow through as control-free bubbles
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   if_valid/if_ready   fetch handshake (if_ready is combinational)
//   if_instruction/if_pc instruction word and its PC from fetch
//   ex_ready            execute consumes the held instruction
//   flush               kill the held instruction, drop the incoming one
//   id_*                registered pc/raw instruction/valid presented to execute
//   opcode..funct7      raw instruction fields
//   imm                 sign-extended immediate
//   reg_write..alu_src  control strobes
//   illegal             unsupported opcode flag
module instruction_decode #(
   parameter int unsigned     XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_0040_0000,
   parameter logic [31:0]     NOP_INSN = 32'h0000_0013
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            if_valid,
   input  logic [31:0]     if_instruction,
   input  logic [XLEN-1:0] if_pc,
   output logic            if_ready,
   input  logic            ex_ready,
   input  logic            flush,
   output logic            id_valid,
   output logic [XLEN-1:0] id_pc,
   output logic [31:0]     id_instruction,
   output logic [6:0]      opcode,
   output logic [4:0]      rd,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [2:0]      funct3,
   output logic [6:0]      funct7,
   output logic [XLEN-1:0] imm,
   output logic            reg_write,
   output logic            mem_read,
   output logic            mem_write,
   output logic            branch,
   output logic            jump,
   output logic            alu_src,
   output logic            illegal
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_R32    = 7'b0111011;

   logic [31:0]     insn;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [XLEN-1:0] imm_dec;
   logic            rw_dec, mr_dec, mw_dec, br_dec, jp_dec, as_dec, ill_dec;

   logic            id_valid_q, id_valid_d;
   logic [XLEN-1:0] id_pc_q, id_pc_d;
   logic [31:0]     id_insn_q, id_insn_d;
   logic [6:0]      opcode_q, opcode_d;
   logic [4:0]      rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
   logic [2:0]      funct3_q, funct3_d;
   logic [6:0]      funct7_q, funct7_d;
   logic [XLEN-1:0] imm_q, imm_d;
   logic [5:0]      ctl_q, ctl_d;
   logic            illegal_q, illegal_d;
   logic            accept;

   assign insn  = if_instruction;
   assign imm_i = {{(XLEN-12){insn[31]}}, insn[31:20]};
   assign imm_s = {{(XLEN-12){insn[31]}}, insn[31:25], insn[11:7]};
   assign imm_b = {{(XLEN-13){insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
   assign imm_u = {{(XLEN-32){insn[31]}}, insn[31:12], 12'h000};
   assign imm_j = {{(XLEN-21){insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};

   always_comb begin
      imm_dec = '0;
      rw_dec  = 1'b0;
      mr_dec  = 1'b0;
      mw_dec  = 1'b0;
      br_dec  = 1'b0;
      jp_dec  = 1'b0;
      as_dec  = 1'b0;
      ill_dec = 1'b0;
      case (insn[6:0])
         OP_LOAD:          begin imm_dec = imm_i; rw_dec = 1'b1; mr_dec = 1'b1; as_dec = 1'b1; end
         OP_IMM, OP_IMM32: begin imm_dec = imm_i; rw_dec = 1'b1; as_dec = 1'b1; end
         OP_JALR:          begin imm_dec = imm_i; rw_dec = 1'b1; jp_dec = 1'b1; as_dec = 1'b1; end
         OP_SYSTEM:        begin imm_dec = imm_i; as_dec = 1'b1; end
         OP_STORE:         begin imm_dec = imm_s; mw_dec = 1'b1; as_dec = 1'b1; end
         OP_BRANCH:        begin imm_dec = imm_b; br_dec = 1'b1; end
         OP_LUI, OP_AUIPC: begin imm_dec = imm_u; rw_dec = 1'b1; as_dec = 1'b1; end
         OP_JAL:           begin imm_dec = imm_j; rw_dec = 1'b1; jp_dec = 1'b1; as_dec = 1'b1; end
         OP_R, OP_R32:     begin rw_dec = 1'b1; end
         default: begin
`ifdef ILLEGAL_CHECK_EN
            ill_dec = 1'b1;
`else
            ill_dec = 1'b0;
`endif
         end
      endcase
      // writes to x0 are architecturally discarded, so never request them
      if (insn[11:7] == 5'd0) rw_dec = 1'b0;
   end

   // an illegal instruction parks in the stage: nothing leaves, nothing enters
   assign if_ready = !illegal_q && (!id_valid_q || ex_ready);
   assign accept   = if_valid && if_ready;

   always_comb begin
      id_valid_d = id_valid_q;
      id_pc_d    = id_pc_q;
      id_insn_d  = id_insn_q;
      opcode_d   = opcode_q;
      rd_d       = rd_q;
      rs1_d      = rs1_q;
      rs2_d      = rs2_q;
      funct3_d   = funct3_q;
      funct7_d   = funct7_q;
      imm_d      = imm_q;
      ctl_d      = ctl_q;
      illegal_d  = illegal_q;
      if (flush) begin
         // pc is kept so the killed slot still reports where it was
         id_valid_d = 1'b0;
         id_insn_d  = NOP_INSN;
         opcode_d   = '0;
         rd_d       = '0;
         rs1_d      = '0;
         rs2_d      = '0;
         funct3_d   = '0;
         funct7_d   = '0;
         imm_d      = '0;
         ctl_d      = '0;
         illegal_d  = 1'b0;
      end else if (accept) begin
         id_valid_d = 1'b1;
         id_pc_d    = if_pc;
         id_insn_d  = insn;
         opcode_d   = insn[6:0];
         rd_d       = insn[11:7];
         rs1_d      = insn[19:15];
         rs2_d      = insn[24:20];
         funct3_d   = insn[14:12];
         funct7_d   = insn[31:25];
         imm_d      = imm_dec;
         ctl_d      = {rw_dec, mr_dec, mw_dec, br_dec, jp_dec, as_dec};
         illegal_d  = ill_dec;
      end else if (id_valid_q && ex_ready && !illegal_q) begin
         id_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         id_valid_q <= 1'b0;
         id_pc_q    <= RESET_PC;
         id_insn_q  <= NOP_INSN;
         opcode_q   <= '0;
         rd_q       <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         funct3_q   <= '0;
         funct7_q   <= '0;
         imm_q      <= '0;
         ctl_q      <= '0;
         illegal_q  <= 1'b0;
      end else begin
         id_valid_q <= id_valid_d;
         id_pc_q    <= id_pc_d;
         id_insn_q  <= id_insn_d;
         opcode_q   <= opcode_d;
         rd_q       <= rd_d;
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         funct3_q   <= funct3_d;
         funct7_q   <= funct7_d;
         imm_q      <= imm_d;
         ctl_q      <= ctl_d;
         illegal_q  <= illegal_d;
      end
   end

   assign id_valid       = id_valid_q;
   assign id_pc          = id_pc_q;
   assign id_instruction = id_insn_q;
   assign opcode         = opcode_q;
   assign rd             = rd_q;
   assign rs1            = rs1_q;
   assign rs2            = rs2_q;
   assign funct3         = funct3_q;
   assign funct7         = funct7_q;
   assign imm            = imm_q;
   assign {reg_write, mem_read, mem_write, branch, jump, alu_src} = ctl_q;
   assign illegal        = illegal_q;

endmodule

// File: tb/tb_instruction_decode.sv
// Randomized scoreboard bench for instruction_decode. Expected decode results are
// computed from the RV64I encoding rules and queued at acceptance; a negedge monitor
// compares them when execute consumes (or flush kills) the held instruction.
module tb_instruction_decode;

   localparam logic [63:0] RESET_PC = 64'h0000_0000_0040_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        if_valid = 1'b0;
   logic [31:0] if_instruction = '0;
   logic [63:0] if_pc = '0;
   logic        if_ready;
   logic        ex_ready = 1'b0;
   logic        flush = 1'b0;
   logic        id_valid;
   logic [63:0] id_pc;
   logic [31:0] id_instruction;
   logic [6:0]  opcode;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [63:0] imm;
   logic        reg_write, mem_read, mem_write, branch, jump, alu_src, illegal;

   instruction_decode dut (
      .clock(clock), .reset(reset), .if_valid(if_valid), .if_instruction(if_instruction),
      .if_pc(if_pc), .if_ready(if_ready), .ex_ready(ex_ready), .flush(flush),
      .id_valid(id_valid), .id_pc(id_pc), .id_instruction(id_instruction),
      .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
      .imm(imm), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
      .branch(branch), .jump(jump), .alu_src(alu_src), .illegal(illegal)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] insn;
      logic [63:0] imm;
      logic [5:0]  ctl;
      logic        illegal;
   } exp_t;

   exp_t        q[$];
   int          n_vec = 0;
   int          n_err = 0;
   logic [63:0] last_pc = RESET_PC;
   bit          flush_prev = 1'b0;
   bit          mon_en = 1'b0;

   logic [6:0] ops [12] = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h23,
                            7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B};

   task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h required %h at %0t", nm, act, req, $time);
      end
   endtask

   function automatic exp_t model(logic [31:0] i, logic [63:0] pc);
      exp_t   e;
      longint s, sh20, sh25, sh31, sh12;
      logic [6:0] op;
      bit     known, is_r, is_b;
      s    = longint'($signed(i));
      sh20 = s >>> 20;
      sh25 = s >>> 25;
      sh31 = s >>> 31;
      sh12 = s >>> 12;
      op   = i[6:0];
      e.pc = pc;
      e.insn = i;
      e.imm  = 64'd0;
      if (op inside {7'h03, 7'h13, 7'h1B, 7'h67, 7'h73}) e.imm = sh20;
      else if (op == 7'h23) e.imm = sh25 * 32 + longint'(i[11:7]);
      else if (op == 7'h63)
         e.imm = sh31 * 4096 + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
      else if (op inside {7'h37, 7'h17}) e.imm = sh12 * 4096;
      else if (op == 7'h6F)
         e.imm = sh31 * 1048576 + longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
      known = op inside {7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B};
      is_r  = op inside {7'h33, 7'h3B};
      is_b  = (op == 7'h63);
      e.ctl[5] = (op inside {7'h33, 7'h3B, 7'h13, 7'h1B, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67}) && (i[11:7] != 0);
      e.ctl[4] = (op == 7'h03);
      e.ctl[3] = (op == 7'h23);
      e.ctl[2] = is_b;
      e.ctl[1] = (op == 7'h6F) || (op == 7'h67);
      e.ctl[0] = known && !is_r && !is_b;
`ifdef ILLEGAL_CHECK_EN
      e.illegal = !known;
`else
      e.illegal = 1'b0;
`endif
      return e;
   endfunction

   // monitor: compares the held instruction at the moment it leaves the stage
   always @(negedge clock) begin
      if (mon_en && reset && id_valid &&
          (flush || (ex_ready && !(q.size() != 0 && q[0].illegal)))) begin
         if (q.size() == 0) begin
            chk("unexpected_id_valid", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("id_pc", id_pc, e.pc);
            chk("id_instruction", {32'd0, id_instruction}, {32'd0, e.insn});
            chk("opcode", {57'd0, opcode}, {57'd0, e.insn[6:0]});
            chk("rd", {59'd0, rd}, {59'd0, e.insn[11:7]});
            chk("rs1", {59'd0, rs1}, {59'd0, e.insn[19:15]});
            chk("rs2", {59'd0, rs2}, {59'd0, e.insn[24:20]});
            chk("funct3", {61'd0, funct3}, {61'd0, e.insn[14:12]});
            chk("funct7", {57'd0, funct7}, {57'd0, e.insn[31:25]});
            chk("imm", imm, e.imm);
            chk("controls", {58'd0, reg_write, mem_read, mem_write, branch, jump, alu_src},
                {58'd0, e.ctl});
            chk("illegal", {63'd0, illegal}, {63'd0, e.illegal});
         end
      end
   end

   task automatic cyc(bit v, logic [31:0] insn, logic [63:0] pc, bit exr, bit fl);
      bit rdy;
      @(posedge clock);
      #2;
      chk("id_valid", {63'd0, id_valid}, {63'd0, q.size() != 0});
      if (flush_prev) begin
         chk("flush_insn", {32'd0, id_instruction}, {32'd0, NOP});
         chk("flush_ctl", {57'd0, reg_write, mem_read, mem_write, branch, jump, alu_src, illegal}, 64'd0);
         chk("flush_pc", id_pc, last_pc);
      end
      if_valid = v; if_instruction = insn; if_pc = pc; ex_ready = exr; flush = fl;
      #1;
      rdy = !(q.size() != 0 && q[0].illegal) && (q.size() == 0 || exr);
      chk("if_ready", {63'd0, if_ready}, {63'd0, rdy});
      if (v && rdy && !fl) begin
         q.push_back(model(insn, pc));
         last_pc = pc;
      end
      flush_prev = fl;
   endtask

   function automatic logic [31:0] rand_insn();
      logic [31:0] r;
      int k;
      r = $urandom();
      k = $urandom_range(0, 13);
      if (k < 12) r[6:0] = ops[k];
      return r;
   endfunction

   initial begin
      repeat (3) @(posedge clock);
      #2;
      chk("rst_id_valid", {63'd0, id_valid}, 64'd0);
      chk("rst_id_pc", id_pc, RESET_PC);
      chk("rst_id_insn", {32'd0, id_instruction}, {32'd0, NOP});
      chk("rst_imm", imm, 64'd0);
      chk("rst_fields", {32'd0, opcode, rd, rs1, rs2, funct3, funct7}, 64'd0);
      chk("rst_illegal", {63'd0, illegal}, 64'd0);
      @(negedge clock);
      reset = 1'b1;
      mon_en = 1'b1;

      // directed: addi, sw, beq with a 3-cycle stall, flush against a valid fetch, 0x7F
      cyc(1, 32'h0050_0093, 64'h1000, 1, 0);
      cyc(1, 32'hFE20_AE23, 64'h1004, 1, 0);
      cyc(1, 32'hFE00_0CE3, 64'h1008, 1, 0);
      repeat (3) cyc(1, 32'h0000_0013, 64'h100C, 0, 0);
      cyc(1, 32'h0010_0113, 64'h100C, 1, 0);
      cyc(1, 32'h0020_0193, 64'h1010, 1, 1);
      cyc(1, 32'h0030_0213, 64'h1014, 1, 0);
      cyc(1, 32'h0000_007F, 64'h1018, 1, 0);
      repeat (3) cyc(1, 32'h0040_0293, 64'h101C, 1, 0);
      cyc(0, 32'h0, 64'h0, 1, 1);
      cyc(1, 32'h0040_0293, 64'h1020, 1, 0);

      for (int n = 0; n < 3000; n++)
         cyc($urandom_range(0, 3) != 0, rand_insn(), {$urandom(), $urandom()},
             $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);

      // asynchronous reset while an instruction is stalled in the stage
      cyc(0, 32'h0, 64'h0, 1, 1);
      cyc(1, 32'hFE20_AE23, 64'h2000, 1, 0);
      cyc(0, 32'h0, 64'h0, 0, 0);
      cyc(0, 32'h0, 64'h0, 0, 0);
      @(posedge clock);
      #2;
      chk("stall_id_valid", {63'd0, id_valid}, 64'd1);
      mon_en = 1'b0;
      reset = 1'b0;
      #1;
      chk("async_rst_id_valid", {63'd0, id_valid}, 64'd0);
      chk("async_rst_id_pc", id_pc, RESET_PC);
      chk("async_rst_imm", imm, 64'd0);
      chk("async_rst_ctl", {58'd0, reg_write, mem_read, mem_write, branch, jump, alu_src}, 64'd0);
      q.delete();
      last_pc = RESET_PC;
      flush_prev = 1'b0;
      if_valid = 1'b0; ex_ready = 1'b0; flush = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      mon_en = 1'b1;
      cyc(1, 32'h0050_0093, 64'h3000, 1, 0);
      cyc(0, 32'h0, 64'h0, 1, 0);
      cyc(0, 32'h0, 64'h0, 1, 0);
      @(posedge clock);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
